// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for a shared 32-bit register bus (port 0: I2C bridge, port 1: debug).
// Latency req->ack: write 3 cycles, read 3+RD_LAT; range-rejected access 2 cycles (REG_ARB_RANGE_CHK_EN).
// Backpressure: req/ack handshake, requests sampled only in IDLE; a waiting master holds req until its ack.
module reg_bus_arbiter #(
    parameter int              AW       = 16,
    parameter int              DW       = 32,
    parameter int              RD_LAT   = 1,
    parameter logic [AW-1:0]   ADDR_MAX = AW'(32'h00FF)
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic [AW-1:0] bus_addr,
    output logic          bus_wr_en,
    output logic          bus_rd_en,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,

    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF);

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic          bad_q, bad_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rd_buf_q, rd_buf_d;

    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic          m0_err_q, m0_err_d;
    logic          m1_err_q, m1_err_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic          gnt_vld;
    logic          gnt_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          range_bad;
    logic [DW-1:0] resp_dat;

    // On a tie the port that did not win last time is served.
    assign gnt_vld   = m0_req | m1_req;
    assign gnt_port  = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    assign sel_we    = gnt_port ? m1_we    : m0_we;
    assign sel_addr  = gnt_port ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_port ? m1_wdata : m0_wdata;

`ifdef REG_ARB_RANGE_CHK_EN
    assign range_bad = (sel_addr > ADDR_MAX);
`else
    logic unused_addr_max;
    assign range_bad       = 1'b0;
    assign unused_addr_max = ^ADDR_MAX;
`endif

    assign resp_dat = bad_q ? ERR_DATA : (we_q ? '0 : rd_buf_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        bad_d        = bad_q;
        lat_cnt_d    = lat_cnt_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        rd_buf_d     = rd_buf_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    win_d        = gnt_port;
                    last_grant_d = gnt_port;
                    we_d         = sel_we;
                    bad_d        = range_bad;
                    // Rejected accesses leave the bus registers untouched and never strobe.
                    if (range_bad) begin
                        state_d = S_RESP;
                    end else begin
                        bus_addr_d  = sel_addr;
                        bus_wdata_d = sel_wdata;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    lat_cnt_d = 3'(RD_LAT);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q <= 3'd1) begin
                    rd_buf_d = bus_rdata;
                    state_d  = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            default: begin
                // Registered response: rdata changes only together with that port's ack.
                if (win_q) begin
                    m1_ack_d   = 1'b1;
                    m1_err_d   = bad_q;
                    m1_rdata_d = resp_dat;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_err_d   = bad_q;
                    m0_rdata_d = resp_dat;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            bad_q        <= 1'b0;
            lat_cnt_q    <= 3'd0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rd_buf_q     <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            bad_q        <= bad_d;
            lat_cnt_q    <= lat_cnt_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rd_buf_q     <= rd_buf_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wr_en = (state_q == S_ISSUE) &  we_q;
    assign bus_rd_en = (state_q == S_ISSUE) & ~we_q;
    assign busy      = (state_q != S_IDLE);

    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios followed by random two-master traffic against a
// transaction-level model (service order, latency, shadow register contents).
module tb_reg_bus_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [15:0] bus_addr;
    logic        bus_wr_en, bus_rd_en;
    logic [31:0] bus_wdata, bus_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    reg_bus_arbiter #(.AW(16), .DW(32), .RD_LAT(RD_LAT), .ADDR_MAX(16'h00FF)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Downstream register file with RD_LAT read pipeline; idle slots carry junk.
    bit   [31:0] dev_mem [bit [15:0]];
    logic [31:0] rd_pipe [RD_LAT];
    assign bus_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= bus_rd_en ? dev_mem[bus_addr] : $urandom;
        if (bus_wr_en) dev_mem[bus_addr] = bus_wdata;
    end

    int          overlap_cnt = 0;
    int          strobe_cnt  = 0;
    int          wr_cnt      = 0;
    logic [15:0] last_wa;
    logic [31:0] last_wd;

    always @(negedge clk) begin
        if (bus_wr_en && bus_rd_en) overlap_cnt++;
        if (bus_wr_en || bus_rd_en) strobe_cnt++;
        if (bus_wr_en) begin
            wr_cnt++;
            last_wa = bus_addr;
            last_wd = bus_wdata;
        end
    end

    // Reference model state
    bit   [31:0] exp_mem [bit [15:0]];
    bit          mdl_last;
    logic [31:0] exp_last_rd [2];
    int          exp_strobes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        mdl_last       = 1'b1;
        exp_last_rd[0] = '0;
        exp_last_rd[1] = '0;
    endtask

    // One arbitration round: each requesting port issues one access and drops req on its ack.
    task automatic run_step(input bit r0, input bit r1, input bit we0, input bit we1,
                            input logic [15:0] a0, input logic [15:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            output int got0, output int got1);
        bit          rq [2];
        bit          wq [2];
        logic [15:0] aq [2];
        logic [31:0] dq [2];
        logic [31:0] exp_rd [2];
        int          exp_at [2];
        int          got [2];
        int          t;
        int          p;
        int          first;
        rq = '{r0, r1}; wq = '{we0, we1}; aq = '{a0, a1}; dq = '{d0, d1};
        exp_at = '{0, 0}; got = '{0, 0}; exp_rd = '{32'h0, 32'h0};

        check("m0_rdata_hold", {32'h0, m0_rdata}, {32'h0, exp_last_rd[0]});
        check("m1_rdata_hold", {32'h0, m1_rdata}, {32'h0, exp_last_rd[1]});

        first = (r0 && r1) ? (mdl_last ? 0 : 1) : (r1 ? 1 : 0);
        t = 0;
        for (int n = 0; n < 2; n++) begin
            p = (n == 0) ? first : 1 - first;
            if (rq[p]) begin
                t += wq[p] ? 3 : 3 + RD_LAT;
                exp_at[p] = t;
                if (wq[p]) begin
                    exp_mem[aq[p]] = dq[p];
                    exp_rd[p] = '0;
                end else begin
                    exp_rd[p] = exp_mem[aq[p]];
                end
                mdl_last = p[0];
                exp_strobes++;
            end
        end

        m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_req = r0;
        m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_req = r1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_active", {63'h0, busy}, 64'h1);
            if (m0_ack) begin
                if (got[0] == 0) got[0] = k;
                check("m0_rdata", {32'h0, m0_rdata}, {32'h0, exp_rd[0]});
                check("m0_err", {63'h0, m0_err}, 64'h0);
                m0_req = 1'b0;
            end
            if (m1_ack) begin
                if (got[1] == 0) got[1] = k;
                check("m1_rdata", {32'h0, m1_rdata}, {32'h0, exp_rd[1]});
                check("m1_err", {63'h0, m1_err}, 64'h0);
                m1_req = 1'b0;
            end
            if ((!r0 || got[0] != 0) && (!r1 || got[1] != 0)) break;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("m0_ack_cycle", 64'(got[0]), 64'(exp_at[0]));
        check("m1_ack_cycle", 64'(got[1]), 64'(exp_at[1]));
        if (r0) exp_last_rd[0] = exp_rd[0];
        if (r1) exp_last_rd[1] = exp_rd[1];
        got0 = got[0];
        got1 = got[1];
    endtask

    initial begin
        int   g0, g1;
        int   wr_before;
        int   order [$];
        bit   r0, r1, w0, w1;
        logic [15:0] ra0, ra1;
        logic [31:0] rd0, rd1;

        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        dev_mem[16'h0020] = 32'hCAFE_F00D;
        exp_mem[16'h0020] = 32'hCAFE_F00D;

        do_reset();
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_acks", {62'h0, m0_ack, m1_ack}, 64'h0);
        check("rst_errs", {62'h0, m0_err, m1_err}, 64'h0);
        check("rst_strobes", {62'h0, bus_wr_en, bus_rd_en}, 64'h0);
        check("rst_m0_rdata", {32'h0, m0_rdata}, 64'h0);
        check("rst_m1_rdata", {32'h0, m1_rdata}, 64'h0);
        check("rst_bus_addr_wdata", {16'h0, bus_addr, bus_wdata}, 64'h0);

        // Single write from port 0
        wr_before = wr_cnt;
        run_step(1, 0, 1, 0, 16'h0010, 16'h0, 32'hA5A5_1234, 32'h0, g0, g1);
        check("wr_strobe_count", 64'(wr_cnt - wr_before), 64'd1);
        check("wr_strobe_addr", {48'h0, last_wa}, 64'h0010);
        check("wr_strobe_data", {32'h0, last_wd}, 64'hA5A5_1234);
        check("bus_addr_holds", {48'h0, bus_addr}, 64'h0010);

        // Single read from port 1
        run_step(0, 1, 0, 0, 16'h0, 16'h0020, 32'h0, 32'h0, g0, g1);
        check("rd_m1_ack_at_4", 64'(g1), 64'd4);

        // Simultaneous reads right after reset: port 0 first
        do_reset();
        run_step(1, 1, 0, 0, 16'h0010, 16'h0020, 32'h0, 32'h0, g0, g1);
        check("tie_m0_before_m1", {63'h0, (g0 < g1)}, 64'h1);

        // Both masters hold req across six accesses
        do_reset();
        order.delete();
        m0_we = 1; m0_addr = 16'h0030; m0_wdata = 32'h1111_0030; m0_req = 1;
        m1_we = 1; m1_addr = 16'h0031; m1_wdata = 32'h2222_0031; m1_req = 1;
        for (int k = 0; k < 100 && order.size() < 6; k++) begin
            @(negedge clk);
            if (m0_ack) order.push_back(0);
            if (m1_ack) order.push_back(1);
        end
        m0_req = 0;
        m1_req = 0;
        check("fair_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check("fair_order", 64'((i < order.size()) ? order[i] : 9), 64'(i % 2));
        exp_mem[16'h0030] = 32'h1111_0030;
        exp_mem[16'h0031] = 32'h2222_0031;
        exp_strobes += 6;
        mdl_last = 1'b1;

        // Reset asserted while the read waits for data
        m0_we = 0; m0_addr = 16'h0020; m0_req = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        m0_req = 1'b0;
        exp_strobes++;
        @(negedge clk);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_acks", {62'h0, m0_ack, m1_ack}, 64'h0);
        check("midrst_strobes", {62'h0, bus_wr_en, bus_rd_en}, 64'h0);
        rst_n = 1'b1;
        mdl_last = 1'b1;
        exp_last_rd[0] = '0;
        exp_last_rd[1] = '0;
        run_step(0, 1, 0, 1, 16'h0, 16'h0005, 32'h0, 32'h5555_AAAA, g0, g1);
        run_step(1, 0, 0, 0, 16'h0005, 16'h0, 32'h0, 32'h0, g0, g1);

`ifdef REG_ARB_RANGE_CHK_EN
        begin
            int s_before;
            int got_ack;
            s_before = strobe_cnt;
            got_ack  = 0;
            m0_we = 0; m0_addr = 16'h0100; m0_req = 1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (m0_ack) begin
                    got_ack = 1;
                    check("range_err", {63'h0, m0_err}, 64'h1);
                    check("range_rdata", {32'h0, m0_rdata}, 64'hDEAD_BEEF);
                    m0_req = 0;
                    break;
                end
            end
            m0_req = 0;
            check("range_ack_seen", 64'(got_ack), 64'd1);
            check("range_no_strobe", 64'(strobe_cnt - s_before), 64'd0);
            mdl_last = 1'b0;
            exp_last_rd[0] = 32'hDEAD_BEEF;
        end
`endif

        // Random two-master traffic over a small address window to force collisions
        for (int i = 0; i < 40; i++) begin
            r0  = 1'($urandom_range(0, 1));
            r1  = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            w0  = 1'($urandom_range(0, 1));
            w1  = 1'($urandom_range(0, 1));
            ra0 = 16'($urandom_range(0, 15));
            ra1 = 16'($urandom_range(0, 15));
            rd0 = $urandom;
            rd1 = $urandom;
            run_step(r0, r1, w0, w1, ra0, ra1, rd0, rd1, g0, g1);
        end

        repeat (3) @(negedge clk);
        check("strobe_overlap", 64'(overlap_cnt), 64'd0);
        check("strobe_total", 64'(strobe_cnt), 64'(exp_strobes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
